// File: rtl/axis_switch_pkg.sv
// rtl/axis_switch_pkg.sv - shared types and helpers for the AXI-Stream round-robin crossbar
package axis_switch_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Index width that never collapses to zero for single-port configurations.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - combinational round-robin picker: first requester at or after ptr
module axis_rr_arbiter
    import axis_switch_pkg::*;
#(
    parameter int  NREQ = 2,
    localparam int IW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx
);

    int            w_sum;
    logic [IW-1:0] w_cand;

    // Scan from the farthest candidate back to ptr so the nearest requester overwrites last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_sum   = 0;
        w_cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum  = int'(i_ptr) + k;
            w_cand = IW'((w_sum >= NREQ) ? (w_sum - NREQ) : w_sum);
            if (i_req[w_cand]) begin
                o_grant         = '0;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/axis_switch_rr_crossbar.sv
// rtl/axis_switch_rr_crossbar.sv - NSLAVES x NMASTERS AXI-Stream crossbar, per-master RR with packet lock
module axis_switch_rr_crossbar
    import axis_switch_pkg::*;
#(
    parameter int NSLAVES    = 2,
    parameter int NMASTERS   = 2,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 2,
    parameter int ID_WIDTH   = 1,
    parameter int HAS_ID     = 0,
    parameter int HAS_LAST   = 0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NSLAVES-1:0]             s_valid,
    output logic [NSLAVES-1:0]             s_ready,
    input  logic [NSLAVES*DATA_WIDTH-1:0]  s_data,
    input  logic [NSLAVES*DEST_WIDTH-1:0]  s_dest,
    input  logic [NSLAVES*ID_WIDTH-1:0]    s_id,
    input  logic [NSLAVES-1:0]             s_last,
    output logic [NMASTERS-1:0]            m_valid,
    input  logic [NMASTERS-1:0]            m_ready,
    output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
    output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
    output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
    output logic [NMASTERS-1:0]            m_last,
    output logic [NSLAVES-1:0]             dest_err
);

    localparam int SW = clog2_min1(NSLAVES);

    state_t                r_state [NMASTERS];
    logic [SW-1:0]         r_owner [NMASTERS];
    logic [SW-1:0]         r_ptr   [NMASTERS];
    logic [NMASTERS-1:0]   r_mvalid;
    logic [DATA_WIDTH-1:0] r_mdata [NMASTERS];
    logic [DEST_WIDTH-1:0] r_mdest [NMASTERS];
    logic [ID_WIDTH-1:0]   r_mid   [NMASTERS];
    logic [NMASTERS-1:0]   r_mlast;
    logic [NSLAVES-1:0]    r_drop;
    logic [NSLAVES-1:0]    r_derr;

    logic [NSLAVES-1:0]    w_req  [NMASTERS];
    logic [NSLAVES-1:0]    w_gnt  [NMASTERS];
    logic [SW-1:0]         w_gidx [NMASTERS];
    logic [NSLAVES-1:0]    w_locked;
    logic [NSLAVES-1:0]    w_lock_ready;
    logic [NSLAVES-1:0]    w_bad;
    logic [NSLAVES-1:0]    w_dropping;
    logic [NMASTERS-1:0]   w_accept;
    logic [NMASTERS-1:0]   w_end;

    always_comb begin
        w_locked     = '0;
        w_lock_ready = '0;
        w_accept     = '0;
        w_end        = '0;
        for (int m = 0; m < NMASTERS; m++) begin
            if (r_state[m] == LOCKED) begin
                w_locked[r_owner[m]]     = 1'b1;
                w_lock_ready[r_owner[m]] = w_lock_ready[r_owner[m]] | !r_mvalid[m] | m_ready[m];
                w_accept[m] = s_valid[r_owner[m]] & (!r_mvalid[m] | m_ready[m]);
            end
            w_end[m] = (HAS_LAST != 0) ? s_last[r_owner[m]] : 1'b1;
        end
        for (int i = 0; i < NSLAVES; i++) begin
            w_bad[i] = s_valid[i] & !w_locked[i] &
                       (32'(s_dest[i*DEST_WIDTH +: DEST_WIDTH]) >= 32'(NMASTERS));
        end
        // A slave mid-drop swallows beats without re-decoding their dest.
        w_dropping = ~w_locked & (r_drop | w_bad);
        s_ready    = w_lock_ready | w_dropping;
        for (int m = 0; m < NMASTERS; m++) begin
            w_req[m] = '0;
            for (int i = 0; i < NSLAVES; i++) begin
                w_req[m][i] = s_valid[i] & !w_locked[i] & !r_drop[i] & (r_state[m] == IDLE) &
                              (32'(s_dest[i*DEST_WIDTH +: DEST_WIDTH]) == 32'(m));
            end
        end
    end

    for (genvar g = 0; g < NMASTERS; g++) begin : g_arb
        axis_rr_arbiter #(.NREQ(NSLAVES)) u_arb (
            .i_req   (w_req[g]),
            .i_ptr   (r_ptr[g]),
            .o_grant (w_gnt[g]),
            .o_idx   (w_gidx[g])
        );
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int m = 0; m < NMASTERS; m++) begin
                r_state[m] <= IDLE;
                r_owner[m] <= '0;
                r_ptr[m]   <= '0;
                r_mdata[m] <= '0;
                r_mdest[m] <= '0;
                r_mid[m]   <= '0;
            end
            r_mvalid <= '0;
            r_mlast  <= '0;
            r_drop   <= '0;
            r_derr   <= '0;
        end else begin
            for (int m = 0; m < NMASTERS; m++) begin
                if (w_accept[m]) begin
                    r_mvalid[m] <= 1'b1;
                    r_mdata[m]  <= s_data[r_owner[m]*DATA_WIDTH +: DATA_WIDTH];
                    r_mdest[m]  <= s_dest[r_owner[m]*DEST_WIDTH +: DEST_WIDTH];
                    r_mid[m]    <= (HAS_ID != 0) ? s_id[r_owner[m]*ID_WIDTH +: ID_WIDTH] : '0;
                    r_mlast[m]  <= w_end[m];
                    if (w_end[m]) begin
                        r_state[m] <= IDLE;
                        r_ptr[m]   <= (int'(r_owner[m]) == NSLAVES - 1) ? '0 : r_owner[m] + 1'b1;
                    end
                end else if (m_ready[m]) begin
                    r_mvalid[m] <= 1'b0;
                end
                if (r_state[m] == IDLE && |w_gnt[m]) begin
                    r_state[m] <= LOCKED;
                    r_owner[m] <= w_gidx[m];
                end
            end
            for (int i = 0; i < NSLAVES; i++) begin
                if (s_valid[i] && w_dropping[i]) begin
                    r_drop[i] <= (HAS_LAST != 0) && !s_last[i];
                end
            end
            r_derr <= r_derr | w_bad;
        end
    end

    always_comb begin
        m_valid  = r_mvalid;
        m_last   = r_mlast;
        dest_err = r_derr;
        m_data   = '0;
        m_dest   = '0;
        m_id     = '0;
        for (int m = 0; m < NMASTERS; m++) begin
            m_data[m*DATA_WIDTH +: DATA_WIDTH] = r_mdata[m];
            m_dest[m*DEST_WIDTH +: DEST_WIDTH] = r_mdest[m];
            m_id[m*ID_WIDTH +: ID_WIDTH]       = r_mid[m];
        end
    end

endmodule

// File: tb/tb_axis_switch_rr_crossbar.sv
// tb/tb_axis_switch_rr_crossbar.sv - self-checking bench for the round-robin AXI-Stream crossbar
module tb_axis_switch_rr_crossbar;

    localparam int NS  = 2;
    localparam int NM  = 2;
    localparam int DW  = 64;
    localparam int DSW = 2;
    localparam int IDW = 2;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NS-1:0]     s_valid = '0;
    logic [NS-1:0]     s_ready;
    logic [NS*DW-1:0]  s_data = '0;
    logic [NS*DSW-1:0] s_dest = '0;
    logic [NS*IDW-1:0] s_id = '0;
    logic [NS-1:0]     s_last = '0;
    logic [NM-1:0]     m_valid;
    logic [NM-1:0]     m_ready = '1;
    logic [NM*DW-1:0]  m_data;
    logic [NM*DSW-1:0] m_dest;
    logic [NM*IDW-1:0] m_id;
    logic [NM-1:0]     m_last;
    logic [NS-1:0]     dest_err;

    typedef struct {
        logic [DW-1:0]  data;
        logic [DSW-1:0] dest;
        logic [IDW-1:0] id;
        logic           last;
        int             cyc;
    } beat_t;

    beat_t sq   [NS][$];
    beat_t mlog [NM][$];
    int    slog [NS][$];
    beat_t expq [NS*NM][$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 aclk = ~aclk;

    axis_switch_rr_crossbar #(
        .NSLAVES(NS), .NMASTERS(NM), .DATA_WIDTH(DW), .DEST_WIDTH(DSW),
        .ID_WIDTH(IDW), .HAS_ID(1), .HAS_LAST(1)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest),
        .s_id(s_id), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dest(m_dest),
        .m_id(m_id), .m_last(m_last), .dest_err(dest_err)
    );

    function automatic logic [DW-1:0] mk(input int s, input int p, input int b);
        return {8'(s), 16'(p), 8'(b), 32'(32'hC0DE0000 + p * 4 + b)};
    endfunction

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            if (sq[s].size() > 0) begin
                s_valid[s]            = 1'b1;
                s_data[s*DW +: DW]    = sq[s][0].data;
                s_dest[s*DSW +: DSW]  = sq[s][0].dest;
                s_id[s*IDW +: IDW]    = sq[s][0].id;
                s_last[s]             = sq[s][0].last;
            end else begin
                s_valid[s] = 1'b0;
                s_last[s]  = 1'b0;
            end
        end
    endtask

    // One clock: present queued beats, record handshakes that the coming edge completes.
    task automatic advance();
        beat_t b;
        drive();
        #1;
        for (int s = 0; s < NS; s++) begin
            if (s_valid[s] && s_ready[s]) begin
                void'(sq[s].pop_front());
                slog[s].push_back(cyc);
            end
        end
        for (int m = 0; m < NM; m++) begin
            if (m_valid[m] && m_ready[m]) begin
                b.data = m_data[m*DW +: DW];
                b.dest = m_dest[m*DSW +: DSW];
                b.id   = m_id[m*IDW +: IDW];
                b.last = m_last[m];
                b.cyc  = cyc;
                mlog[m].push_back(b);
            end
        end
        @(negedge aclk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic push_pkt(input int s, input int p, input int len, input logic [DSW-1:0] dest);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.data = mk(s, p, b);
            x.dest = dest;
            x.id   = IDW'(p);
            x.last = (b == len - 1);
            x.cyc  = 0;
            sq[s].push_back(x);
        end
    endtask

    task automatic clear_logs();
        for (int m = 0; m < NM; m++) mlog[m].delete();
        for (int s = 0; s < NS; s++) slog[s].delete();
    endtask

    task automatic test_reset();
        n_checks++;
        if (m_valid !== 2'b00) begin n_fail++; $display("FAIL reset_m_valid got %b want 00", m_valid); end
        n_checks++;
        if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
        n_checks++;
        if (dest_err !== 2'b00) begin n_fail++; $display("FAIL reset_dest_err got %b want 00", dest_err); end
        n_checks++;
        if (s_ready !== 2'b00) begin n_fail++; $display("FAIL reset_s_ready got %b want 00", s_ready); end
    endtask

    task automatic test_rr_single_beat();
        int t = 0;
        clear_logs();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, p, 1, 2'd0);
            push_pkt(1, p, 1, 2'd0);
        end
        while (mlog[0].size() < 8 && t < 60) begin advance(); t++; end
        n_checks++;
        if (mlog[0].size() != 8) begin n_fail++; $display("FAIL rr_count got %0d want 8", mlog[0].size()); end
        for (int j = 0; j < mlog[0].size() && j < 8; j++) begin
            n_checks++;
            if ({mlog[0][j].data, mlog[0][j].last} !== {mk(j % 2, j / 2, 0), 1'b1}) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got %h want %h", j, mlog[0][j].data, mk(j % 2, j / 2, 0));
            end
            if (j > 0) begin
                n_checks++;
                if (mlog[0][j].cyc - mlog[0][j-1].cyc != 2) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d] got %0d want 2", j, mlog[0][j].cyc - mlog[0][j-1].cyc);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        int t = 0;
        logic [DW-1:0] want;
        clear_logs();
        push_pkt(0, 10, 4, 2'd0);
        advance();
        push_pkt(1, 11, 2, 2'd0);
        while (mlog[0].size() < 6 && t < 60) begin advance(); t++; end
        n_checks++;
        if (mlog[0].size() != 6) begin n_fail++; $display("FAIL lock_count got %0d want 6", mlog[0].size()); end
        for (int j = 0; j < mlog[0].size() && j < 6; j++) begin
            want = (j < 4) ? mk(0, 10, j) : mk(1, 11, j - 4);
            n_checks++;
            if ({mlog[0][j].data, mlog[0][j].last} !== {want, 1'((j == 3) || (j == 5))}) begin
                n_fail++;
                $display("FAIL lock_beat[%0d] got %h/%b want %h", j, mlog[0][j].data, mlog[0][j].last, want);
            end
            if (j > 0) begin
                n_checks++;
                if (mlog[0][j].cyc - mlog[0][j-1].cyc != ((j == 4) ? 2 : 1)) begin
                    n_fail++;
                    $display("FAIL lock_spacing[%0d] got %0d", j, mlog[0][j].cyc - mlog[0][j-1].cyc);
                end
            end
        end
    endtask

    task automatic test_parallel();
        int t = 0;
        beat_t x;
        clear_logs();
        x.data = 64'hA5; x.dest = 2'd0; x.id = 2'd1; x.last = 1'b1; x.cyc = 0;
        sq[0].push_back(x);
        x.data = 64'h5A; x.dest = 2'd1; x.id = 2'd2;
        sq[1].push_back(x);
        while ((mlog[0].size() < 1 || mlog[1].size() < 1) && t < 20) begin advance(); t++; end
        n_checks++;
        if (mlog[0].size() != 1 || mlog[1].size() != 1 || slog[0].size() != 1 || slog[1].size() != 1) begin
            n_fail++;
            $display("FAIL par_count got %0d/%0d want 1/1", mlog[0].size(), mlog[1].size());
        end else begin
            n_checks++;
            if ({mlog[0][0].data, mlog[0][0].id} !== {64'hA5, 2'd1}) begin
                n_fail++; $display("FAIL par_m0_data got %h want a5", mlog[0][0].data);
            end
            n_checks++;
            if ({mlog[1][0].data, mlog[1][0].dest, mlog[1][0].id} !== {64'h5A, 2'd1, 2'd2}) begin
                n_fail++; $display("FAIL par_m1_data got %h want 5a", mlog[1][0].data);
            end
            n_checks++;
            if (mlog[0][0].cyc - slog[0][0] != 1) begin
                n_fail++; $display("FAIL par_m0_latency got %0d want 1", mlog[0][0].cyc - slog[0][0]);
            end
            n_checks++;
            if (mlog[1][0].cyc - slog[1][0] != 1) begin
                n_fail++; $display("FAIL par_m1_latency got %0d want 1", mlog[1][0].cyc - slog[1][0]);
            end
            n_checks++;
            if (mlog[0][0].cyc != mlog[1][0].cyc) begin
                n_fail++; $display("FAIL par_same_cycle got %0d vs %0d", mlog[0][0].cyc, mlog[1][0].cyc);
            end
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        clear_logs();
        push_pkt(0, 20, 4, 2'd0);
        while (mlog[0].size() < 2 && t < 20) begin advance(); t++; end
        m_ready[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            advance();
            #1;
            n_checks++;
            if (m_valid[0] !== 1'b1 || m_data[DW-1:0] !== mk(0, 20, 2)) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got %b/%h want 1/%h", c, m_valid[0], m_data[DW-1:0], mk(0, 20, 2));
            end
            n_checks++;
            if (s_ready[0] !== 1'b0) begin n_fail++; $display("FAIL stall_s_ready[%0d] got %b want 0", c, s_ready[0]); end
        end
        m_ready = 2'b11;
        t = 0;
        while (mlog[0].size() < 4 && t < 20) begin advance(); t++; end
        repeat (3) advance();
        n_checks++;
        if (mlog[0].size() != 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", mlog[0].size()); end
        for (int j = 0; j < mlog[0].size() && j < 4; j++) begin
            n_checks++;
            if (mlog[0][j].data !== mk(0, 20, j)) begin
                n_fail++; $display("FAIL stall_beat[%0d] got %h want %h", j, mlog[0][j].data, mk(0, 20, j));
            end
        end
    endtask

    task automatic test_bad_dest();
        clear_logs();
        push_pkt(1, 40, 3, 2'd3);
        for (int c = 0; c < 8; c++) begin
            advance();
            #1;
            n_checks++;
            if (m_valid !== 2'b00) begin n_fail++; $display("FAIL drop_m_valid[%0d] got %b want 00", c, m_valid); end
        end
        n_checks++;
        if (slog[1].size() != 3) begin
            n_fail++; $display("FAIL drop_accept_count got %0d want 3", slog[1].size());
        end else begin
            n_checks++;
            if (slog[1][2] - slog[1][0] != 2) begin
                n_fail++; $display("FAIL drop_accept_span got %0d want 2", slog[1][2] - slog[1][0]);
            end
        end
        n_checks++;
        if (dest_err !== 2'b10) begin n_fail++; $display("FAIL drop_dest_err got %b want 10", dest_err); end
    endtask

    task automatic test_reset_mid_packet();
        int t = 0;
        clear_logs();
        push_pkt(0, 50, 4, 2'd0);
        while (mlog[0].size() < 1 && t < 20) begin advance(); t++; end
        for (int s = 0; s < NS; s++) sq[s].delete();
        aresetn = 1'b0;
        advance();
        aresetn = 1'b1;
        #1;
        n_checks++;
        if (m_valid !== 2'b00) begin n_fail++; $display("FAIL rst_mid_m_valid got %b want 00", m_valid); end
        n_checks++;
        if (dest_err !== 2'b00) begin n_fail++; $display("FAIL rst_mid_dest_err got %b want 00", dest_err); end
        clear_logs();
        push_pkt(1, 61, 1, 2'd0);
        push_pkt(0, 60, 1, 2'd0);
        t = 0;
        while (mlog[0].size() < 2 && t < 20) begin advance(); t++; end
        n_checks++;
        if (mlog[0].size() != 2) begin
            n_fail++; $display("FAIL rst_mid_count got %0d want 2", mlog[0].size());
        end else begin
            n_checks++;
            if (mlog[0][0].data !== mk(0, 60, 0) || mlog[0][1].data !== mk(1, 61, 0)) begin
                n_fail++;
                $display("FAIL rst_mid_order got %h,%h want %h,%h", mlog[0][0].data, mlog[0][1].data, mk(0, 60, 0), mk(1, 61, 0));
            end
        end
    endtask

    // Scoreboard: per (slave, master) order, whole packets contiguous, bad-dest packets vanish.
    task automatic test_random();
        logic [NS-1:0]  err_exp = '0;
        logic [DSW-1:0] d0;
        int             len;
        int             t = 0;
        int             src;
        int             cur;
        logic           mid;
        beat_t          x;
        beat_t          e;
        clear_logs();
        for (int q = 0; q < NS * NM; q++) expq[q].delete();
        for (int s = 0; s < NS; s++) begin
            for (int p = 0; p < 12; p++) begin
                len = $urandom_range(1, 3);
                d0  = DSW'($urandom_range(0, 3));
                if (d0 >= 2) err_exp[s] = 1'b1;
                for (int b = 0; b < len; b++) begin
                    x.data = {8'(s), 16'(p), 8'(b), 32'($urandom)};
                    x.dest = (b == 0) ? d0 : DSW'($urandom_range(0, 3));
                    x.id   = IDW'($urandom);
                    x.last = (b == len - 1);
                    x.cyc  = 0;
                    sq[s].push_back(x);
                    if (d0 < 2) expq[s*NM + int'(d0)].push_back(x);
                end
            end
        end
        while ((sq[0].size() + sq[1].size() != 0 || m_valid != 0) && t < 4000) begin
            for (int m = 0; m < NM; m++) begin
                m_ready[m] = (sq[0].size() + sq[1].size() == 0) || ($urandom_range(0, 3) != 0);
            end
            advance();
            t++;
        end
        m_ready = 2'b11;
        n_checks++;
        if (t >= 4000) begin n_fail++; $display("FAIL rnd_timeout got %0d cycles want <4000", t); end
        for (int m = 0; m < NM; m++) begin
            mid = 1'b0;
            cur = 0;
            for (int j = 0; j < mlog[m].size(); j++) begin
                src = int'(mlog[m][j].data[DW-1:DW-8]);
                n_checks++;
                if (src >= NS || expq[(src % NS)*NM + m].size() == 0) begin
                    n_fail++; $display("FAIL rnd_unexpected m%0d got %h want none", m, mlog[m][j].data);
                end else begin
                    e = expq[src*NM + m].pop_front();
                    n_checks++;
                    if ({mlog[m][j].data, mlog[m][j].dest, mlog[m][j].id, mlog[m][j].last} !==
                        {e.data, e.dest, e.id, e.last}) begin
                        n_fail++;
                        $display("FAIL rnd_beat m%0d got %h/%0d/%0d/%b want %h/%0d/%0d/%b", m,
                                 mlog[m][j].data, mlog[m][j].dest, mlog[m][j].id, mlog[m][j].last,
                                 e.data, e.dest, e.id, e.last);
                    end
                end
                if (mid) begin
                    n_checks++;
                    if (src != cur) begin n_fail++; $display("FAIL rnd_interleave m%0d got src %0d want %0d", m, src, cur); end
                end
                mid = !mlog[m][j].last;
                cur = src;
            end
        end
        for (int q = 0; q < NS * NM; q++) begin
            n_checks++;
            if (expq[q].size() != 0) begin
                n_fail++; $display("FAIL rnd_missing s%0d m%0d got %0d left want 0", q / NM, q % NM, expq[q].size());
            end
        end
        n_checks++;
        if (dest_err !== err_exp) begin n_fail++; $display("FAIL rnd_dest_err got %b want %b", dest_err, err_exp); end
    endtask

    initial begin
        drive();
        repeat (2) @(negedge aclk);
        #1;
        aresetn = 1'b1;
        test_reset();
        test_rr_single_beat();
        test_packet_lock();
        test_parallel();
        test_backpressure();
        test_bad_dest();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
